// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-programmable pattern of
// 1..MAX_LEN bits, overlap or non-overlap mode, and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned         MAX_LEN     = 8,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  DEF_PATTERN = 8'b0000_1010,
    parameter int unsigned         DEF_LEN     = 4,
    parameter logic                DEF_OVERLAP = 1'b1,
    localparam int unsigned        LW          = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               x,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]      len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_n;
    logic [LW-1:0]      fill_n;
    logic               cfg_ok;
    logic               hit;

    // Mask selecting the low len_q bits of the history/pattern for comparison.
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
    end

    // Next-state: config load, bit acceptance, hit detection and counter update.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;
        err_d     = err_q;

        hist_n = {hist_q[MAX_LEN-2:0], x};
        fill_n = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
        hit    = (fill_n >= len_q) && ((hist_n & len_mask) == (pattern_q & len_mask));
        cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

        if (cfg_load) begin
            // Any load, legal or not, abandons the partial match and drops x.
            hist_d = '0;
            fill_d = '0;
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
            end else begin
                err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d  = hist_n;
            fill_d  = (hit && !overlap_q) ? '0 : fill_n;
            match_d = hit;
            if (hit && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (8-bit and 2-bit counters) share stimulus
// and are compared every cycle against a queue-based model of the matching rules.
module tb_seq_detector_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LW      = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               x = 1'b0;
    logic               clr_cnt = 1'b0;

    logic               match_a, err_a, match_b, err_b;
    logic [7:0]         cnt_a;
    logic [1:0]         cnt_b;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .clr_cnt(clr_cnt), .match(match_a), .match_cnt(cnt_a), .cfg_err(err_a)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .clr_cnt(clr_cnt), .match(match_b), .match_cnt(cnt_b), .cfg_err(err_b)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: accepted bits since the last clear, oldest first.
    bit          m_bits[$];
    logic [7:0]  m_pat;
    int unsigned m_len;
    bit          m_ovl;
    int unsigned m_cnt8, m_cnt2;
    bit          m_err;
    bit          exp_match;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("match",  {31'd0, match_a}, {31'd0, exp_match});
        chk("match2", {31'd0, match_b}, {31'd0, exp_match});
        chk("cnt8",   {24'd0, cnt_a},   m_cnt8);
        chk("cnt2",   {30'd0, cnt_b},   m_cnt2);
        chk("err",    {31'd0, err_a},   {31'd0, m_err});
        chk("err2",   {31'd0, err_b},   {31'd0, m_err});
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat = 8'b0000_1010; m_len = 4; m_ovl = 1'b1;
        m_cnt8 = 0; m_cnt2 = 0; m_err = 1'b0; exp_match = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_load = 1'b0; in_valid = 1'($urandom); x = 1'($urandom); clr_cnt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    task automatic step(input bit ld, input logic [7:0] pat, input int unsigned len,
                        input bit ovl, input bit v, input bit xb, input bit clr);
        bit hit;
        int unsigned n;
        cfg_load = ld; cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ovl;
        in_valid = v; x = xb; clr_cnt = clr;
        exp_match = 1'b0;
        if (ld) begin
            m_bits.delete();
            if (len >= 1 && len <= MAX_LEN) begin
                m_pat = pat; m_len = len; m_ovl = ovl;
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            m_bits.push_back(xb);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            n = m_bits.size();
            if (n >= m_len) begin
                hit = 1'b1;
                for (int unsigned k = 0; k < m_len; k++)
                    if (m_bits[n - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
                if (hit) begin
                    exp_match = 1'b1;
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (!m_ovl) m_bits.delete();
                end
            end
        end
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    // Accepted bit with junk on the cfg inputs (must have no effect without cfg_load).
    task automatic bit_in(input bit xb);
        step(1'b0, 8'($urandom), $urandom_range(0, 15), 1'($urandom), 1'b1, xb, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'($urandom), $urandom_range(0, 15), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input int unsigned len, input bit ovl);
        step(1'b1, pat, len, ovl, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        logic [7:0] bits6;
        logic [7:0] p8;
        model_reset();
        do_reset();

        // Default 1010 with overlap: hits after bits 4 and 6.
        bits6 = 8'b0010_1010;
        for (int i = 5; i >= 0; i--) bit_in(bits6[i]);
        chk("default_cnt", {24'd0, cnt_a}, 32'd2);

        // Non-overlapping 1010: hits after bits 4 and 8 only.
        load(8'b0000_1010, 4, 1'b0);
        for (int i = 0; i < 8; i++) bit_in(i % 2 == 0);
        chk("nonovl_cnt", {24'd0, cnt_a}, 32'd4);

        // 111 overlapping with in_valid gaps.
        load(8'b0000_0111, 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1);
            idle();
        end
        chk("gap_cnt", {24'd0, cnt_a}, 32'd7);

        // Illegal loads keep the previous config and set sticky cfg_err.
        load(8'b0000_1010, 4, 1'b1);
        load(8'b0000_0001, 0, 1'b1);
        load(8'b0000_0001, 9, 1'b1);
        chk("err_sticky", {31'd0, err_a}, 32'd1);
        for (int i = 0; i < 4; i++) bit_in(i % 2 == 0);
        chk("bad_load_match", {31'd0, match_a}, 32'd1);

        // Maximum length pattern.
        p8 = 8'hA5;
        load(p8, 8, 1'b1);
        for (int i = 7; i >= 0; i--) bit_in(p8[i]);
        chk("len8_match", {31'd0, match_a}, 32'd1);

        // Len-1 pattern: consecutive pulses, 2-bit saturation, clr wins on a hit edge.
        load(8'b0000_0001, 1, 1'b1);
        step(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) bit_in(1'b1);
        chk("sat2", {30'd0, cnt_b}, 32'd3);
        step(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_hit_cnt", {30'd0, cnt_b}, 32'd0);
        chk("clr_hit_match", {31'd0, match_b}, 32'd1);

        // Reset mid-sequence discards the partial match.
        do_reset();
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        do_reset();
        bit_in(1'b0);
        chk("rst_nomatch", {31'd0, match_a}, 32'd0);
        for (int i = 0; i < 4; i++) bit_in(i % 2 == 0);
        chk("rst_cnt", {24'd0, cnt_a}, 32'd1);

        // Randomised traffic with occasional loads (some illegal) and clears.
        for (int i = 0; i < 600; i++) begin
            int unsigned r, len;
            r = $urandom_range(0, 99);
            len = $urandom_range(0, 6);
            if (len == 6) len = 9;
            step(r < 4, 8'($urandom), (r < 4) ? len : $urandom_range(0, 15), 1'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 59) == 0);
        end

        // 8-bit counter saturation.
        do_reset();
        load(8'b0000_0001, 1, 1'b1);
        for (int i = 0; i < 260; i++) bit_in(1'b1);
        chk("sat8", {24'd0, cnt_a}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
